// File: rtl/axi_spm_slave.sv
// AXI4 scratchpad responder: DEPTH_WORDS x 32 register array, independent read and write engines.
// Latency: first R beat one cycle after AR handshake, B one cycle after the final W beat.
// Backpressure: R outputs held while rready_i=0, B held until bready_i; one burst per channel in flight.
module axi_spm_slave #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [3:0]  arid_i,
    input  logic [31:0] araddr_i,
    input  logic [7:0]  arlen_i,
    input  logic [2:0]  arsize_i,
    input  logic [1:0]  arburst_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic [3:0]  rid_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rlast_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    input  logic [3:0]  awid_i,
    input  logic [31:0] awaddr_i,
    input  logic [7:0]  awlen_i,
    input  logic [2:0]  awsize_i,
    input  logic [1:0]  awburst_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [3:0]  wid_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wlast_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic [3:0]  bid_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int BW = AW + 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH_WORDS];

    // Only the byte-address bits that select a word are kept, so INCR wraps modulo the depth.
    function automatic logic [AW-1:0] widx(input logic [BW-1:0] a);
        return a[BW-1:2];
    endfunction

    function automatic logic [BW-1:0] next_addr(input logic [BW-1:0] a, input logic [2:0] size,
                                                input logic [1:0] burst);
        return (burst == 2'b01) ? a + ({{(BW-1){1'b0}}, 1'b1} << size) : a;
    endfunction

    function automatic logic bad_xfer(input logic [2:0] size, input logic [1:0] burst);
        return (size > 3'd2) || burst[1];
    endfunction

    logic unused_inputs;
    assign unused_inputs = ^{wid_i, araddr_i[31:BW], awaddr_i[31:BW]};

    // ---------------- read engine ----------------
    r_state_t       r_state, r_state_nxt;
    logic [BW-1:0]  r_addr, r_addr_nxt;
    logic [7:0]     r_len, r_beat;
    logic [2:0]     r_size;
    logic [1:0]     r_burst;
    logic           r_err, ar_hs, r_hs, ar_bad;

    assign arready_o  = (r_state == R_IDLE);
    assign rvalid_o   = (r_state == R_DATA);
    assign ar_hs      = arvalid_i & arready_o;
    assign r_hs       = rvalid_o & rready_i;
    assign ar_bad     = bad_xfer(arsize_i, arburst_i);
    assign r_addr_nxt = next_addr(r_addr, r_size, r_burst);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= R_IDLE;
        else          r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
            R_DATA:  if (r_hs && rlast_o) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
            rid_o   <= '0;
            rdata_o <= '0;
            rresp_o <= '0;
            rlast_o <= 1'b0;
        end else if (ar_hs) begin
            r_addr  <= araddr_i[BW-1:0];
            r_len   <= arlen_i;
            r_beat  <= '0;
            r_size  <= arsize_i;
            r_burst <= arburst_i;
            r_err   <= ar_bad;
            rid_o   <= arid_i;
            rdata_o <= ar_bad ? 32'd0 : mem[widx(araddr_i[BW-1:0])];
            rresp_o <= ar_bad ? RESP_SLVERR : RESP_OKAY;
            rlast_o <= (arlen_i == 8'd0);
        end else if (r_hs) begin
            if (rlast_o) begin
                rlast_o <= 1'b0;
            end else begin
                r_addr  <= r_addr_nxt;
                r_beat  <= r_beat + 8'd1;
                rdata_o <= r_err ? 32'd0 : mem[widx(r_addr_nxt)];
                rlast_o <= (r_beat + 8'd1 == r_len);
            end
        end
    end

    // ---------------- write engine ----------------
    w_state_t       w_state, w_state_nxt;
    logic [BW-1:0]  w_addr;
    logic [7:0]     w_len, w_beat;
    logic [2:0]     w_size;
    logic [1:0]     w_burst;
    logic           w_err, w_bad, aw_hs, w_hs, w_final, wlast_bad;

    assign awready_o = (w_state == W_IDLE);
    assign wready_o  = (w_state == W_DATA);
    assign bvalid_o  = (w_state == W_RESP);
    assign aw_hs     = awvalid_i & awready_o;
    assign w_hs      = wvalid_i & wready_o;
    assign w_final   = w_hs && (w_beat == w_len);
    // The beat counter ends the burst; a misplaced wlast only poisons the response.
    assign wlast_bad = wlast_i != (w_beat == w_len);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) w_state <= W_IDLE;
        else          w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_final) w_state_nxt = W_RESP;
            W_RESP:  if (bready_i) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
            w_bad   <= 1'b0;
            bid_o   <= '0;
            bresp_o <= '0;
        end else if (aw_hs) begin
            w_addr  <= awaddr_i[BW-1:0];
            w_len   <= awlen_i;
            w_beat  <= '0;
            w_size  <= awsize_i;
            w_burst <= awburst_i;
            w_err   <= 1'b0;
            w_bad   <= bad_xfer(awsize_i, awburst_i);
            bid_o   <= awid_i;
        end else if (w_hs) begin
            if (wlast_bad) w_err <= 1'b1;
            if (w_beat == w_len) begin
                bresp_o <= (w_err || wlast_bad || w_bad) ? RESP_SLVERR : RESP_OKAY;
            end else begin
                w_beat <= w_beat + 8'd1;
                w_addr <= next_addr(w_addr, w_size, w_burst);
            end
        end
    end

    // Storage is not reset; write-enable depends on reset-cleared state only.
    always_ff @(posedge clk_i) begin
        if (w_hs && !w_bad) begin
            for (int k = 0; k < 4; k++) begin
                if (wstrb_i[k]) mem[widx(w_addr)][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_spm_slave.sv
// Randomised scoreboard bench for axi_spm_slave: a word-array model predicts every R beat and B response,
// a monitor compares whatever the DUT presents against the queue heads.
module tb_axi_spm_slave;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [3:0]  arid_i = '0, awid_i = '0, wid_i = '0, wstrb_i = '0;
    logic [31:0] araddr_i = '0, awaddr_i = '0, wdata_i = '0;
    logic [7:0]  arlen_i = '0, awlen_i = '0;
    logic [2:0]  arsize_i = '0, awsize_i = '0;
    logic [1:0]  arburst_i = '0, awburst_i = '0;
    logic        arvalid_i = 1'b0, awvalid_i = 1'b0, wvalid_i = 1'b0, wlast_i = 1'b0;
    logic        rready_i = 1'b0, bready_i = 1'b0;
    logic        arready_o, rlast_o, rvalid_o, awready_o, wready_o, bvalid_o;
    logic [3:0]  rid_o, bid_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o, bresp_o;

    axi_spm_slave #(.DEPTH_WORDS(256)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
        .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
        .rvalid_o(rvalid_o), .rready_i(rready_i),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
        .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rexp_t       rq[$];
    bexp_t       bq[$];
    logic [31:0] model [256];
    logic [31:0] wdat [256];
    logic [3:0]  wstb [256];
    bit          rr_toggle = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (timeout or unexpected response)", name);
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 256);
    endfunction

    task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
        logic        bad;
        logic [31:0] a;
        int          n;
        bad = (size > 3'd2) || (burst > 2'd1);
        a   = addr;
        for (int b = 0; b <= int'(len); b++) begin
            rexp_t e;
            e.id   = id;
            e.data = bad ? 32'd0 : model[widx(a)];
            e.resp = bad ? 2'b10 : 2'b00;
            e.last = (b == int'(len));
            rq.push_back(e);
            if (burst == 2'd1) a = a + (32'd1 << size);
        end
        arid_i = id; araddr_i = addr; arlen_i = len; arsize_i = size; arburst_i = burst;
        arvalid_i = 1'b1;
        n = 0;
        while (!arready_o && n < 300) begin tick; n++; end
        if (n >= 300) fail_now("ar_handshake");
        tick;
        arvalid_i = 1'b0;
        chk("r_first_beat_latency", {31'd0, rvalid_o}, 32'd1);
    endtask

    task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input int bad_beat);
        logic        bad, err;
        logic [31:0] a;
        int          n;
        bad = (size > 3'd2) || (burst > 2'd1);
        err = bad;
        a   = addr;
        awid_i = id; awaddr_i = addr; awlen_i = len; awsize_i = size; awburst_i = burst;
        awvalid_i = 1'b1;
        n = 0;
        while (!awready_o && n < 300) begin tick; n++; end
        if (n >= 300) fail_now("aw_handshake");
        tick;
        awvalid_i = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            if ($urandom_range(0, 3) == 0) begin wvalid_i = 1'b0; tick; end
            wid_i   = 4'($urandom);
            wdata_i = wdat[b];
            wstrb_i = wstb[b];
            wlast_i = (b == int'(len)) != (b == bad_beat);
            if (b == bad_beat) err = 1'b1;
            wvalid_i = 1'b1;
            n = 0;
            while (!wready_o && n < 50) begin tick; n++; end
            if (n >= 50) fail_now("w_ready");
            if (!bad) begin
                for (int k = 0; k < 4; k++)
                    if (wstb[b][k]) model[widx(a)][8*k +: 8] = wdat[b][8*k +: 8];
            end
            if (b == int'(len)) begin
                bexp_t e;
                e.id   = id;
                e.resp = err ? 2'b10 : 2'b00;
                bq.push_back(e);
            end
            tick;
            if (burst == 2'd1) a = a + (32'd1 << size);
        end
        wvalid_i = 1'b0;
        wlast_i  = 1'b0;
        chk("b_valid_latency", {31'd0, bvalid_o}, 32'd1);
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while ((rq.size() != 0 || bq.size() != 0 || rvalid_o || bvalid_o) && n < 3000) begin
            tick;
            n++;
        end
        if (n >= 3000) fail_now("drain");
    endtask

    // Ready drivers: random backpressure, or strict alternation on the R channel.
    initial forever begin
        @(posedge clk_i);
        #1;
        rready_i = rr_toggle ? !rready_i : ($urandom_range(0, 3) != 0);
        bready_i = ($urandom_range(0, 2) != 0);
    end

    // Monitor: compares the presented beat against the queue head every cycle, pops on handshake.
    initial forever begin
        @(negedge clk_i);
        if (rst_n_i) begin
            if (rvalid_o) begin
                if (rq.size() == 0) fail_now("r_unexpected_beat");
                else begin
                    chk("rid", {28'd0, rid_o}, {28'd0, rq[0].id});
                    chk("rdata", rdata_o, rq[0].data);
                    chk("rresp", {30'd0, rresp_o}, {30'd0, rq[0].resp});
                    chk("rlast", {31'd0, rlast_o}, {31'd0, rq[0].last});
                    if (rready_i) void'(rq.pop_front());
                end
            end
            if (bvalid_o) begin
                if (bq.size() == 0) fail_now("b_unexpected_resp");
                else begin
                    chk("bid", {28'd0, bid_o}, {28'd0, bq[0].id});
                    chk("bresp", {30'd0, bresp_o}, {30'd0, bq[0].resp});
                    if (bready_i) void'(bq.pop_front());
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] sz;
        logic [1:0] bu;
        int         bb, len;

        repeat (2) @(negedge clk_i);
        chk("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
        chk("rst_rlast", {31'd0, rlast_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_rid", {28'd0, rid_o}, 32'd0);
        chk("rst_rresp", {30'd0, rresp_o}, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid_o}, 32'd0);
        chk("rst_bid", {28'd0, bid_o}, 32'd0);
        chk("rst_bresp", {30'd0, bresp_o}, 32'd0);
        chk("rst_wready", {31'd0, wready_o}, 32'd0);
        chk("rst_arready", {31'd0, arready_o}, 32'd1);
        chk("rst_awready", {31'd0, awready_o}, 32'd1);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick;

        for (int i = 0; i < 256; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        wr(4'd1, 32'h0, 8'd255, 3'd2, 2'd1, -1);
        wait_idle;

        wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
        wr(4'd3, 32'h10, 8'd0, 3'd2, 2'd1, -1);
        wait_idle;
        rd(4'd5, 32'h10, 8'd0, 3'd2, 2'd1);
        wait_idle;

        wdat[0] = 32'hFFFFFFFF;
        wr(4'd2, 32'h20, 8'd0, 3'd2, 2'd1, -1);
        wait_idle;
        wdat[0] = 32'h11223344; wstb[0] = 4'h5;
        wr(4'd2, 32'h20, 8'd0, 3'd2, 2'd1, -1);
        wait_idle;
        rd(4'd6, 32'h20, 8'd0, 3'd2, 2'd1);
        wait_idle;

        for (int i = 0; i < 4; i++) begin wdat[i] = i + 1; wstb[i] = 4'hF; end
        wr(4'd4, 32'h3F8, 8'd3, 3'd2, 2'd1, -1);
        wait_idle;
        rr_toggle = 1'b1;
        rd(4'd7, 32'h3F8, 8'd3, 3'd2, 2'd1);
        wait_idle;
        rr_toggle = 1'b0;
        rd(4'd7, 32'h0, 8'd1, 3'd2, 2'd1);
        wait_idle;

        rd(4'd8, 32'h40, 8'd1, 3'd3, 2'd1);
        wait_idle;
        wdat[0] = 32'hAABBCCDD; wstb[0] = 4'hF;
        wr(4'd9, 32'h40, 8'd0, 3'd2, 2'd1, -1);
        wait_idle;
        wdat[0] = 32'h12345678;
        wr(4'd10, 32'h40, 8'd0, 3'd2, 2'd2, -1);
        wait_idle;
        rd(4'd11, 32'h40, 8'd0, 3'd2, 2'd1);
        wait_idle;
        wdat[0] = 32'h0BAD0001; wdat[1] = 32'h0BAD0002; wstb[1] = 4'hF;
        wr(4'd12, 32'h50, 8'd1, 3'd2, 2'd1, 0);
        wait_idle;

        for (int i = 0; i < 6; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        fork
            wr(4'd13, 32'h100, 8'd5, 3'd2, 2'd1, -1);
            rd(4'd14, 32'h200, 8'd5, 3'd2, 2'd1);
        join
        wait_idle;
        rd(4'd15, 32'h100, 8'd5, 3'd2, 2'd1);
        wait_idle;

        rd(4'hA, 32'h0, 8'd15, 3'd2, 2'd1);
        repeat (3) tick;
        @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        rq.delete();
        #1;
        chk("midrst_rvalid", {31'd0, rvalid_o}, 32'd0);
        chk("midrst_rlast", {31'd0, rlast_o}, 32'd0);
        chk("midrst_arready", {31'd0, arready_o}, 32'd1);
        chk("midrst_awready", {31'd0, awready_o}, 32'd1);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick;
        rd(4'hB, 32'h0, 8'd3, 3'd2, 2'd1);
        wait_idle;

        for (int t = 0; t < 60; t++) begin
            len = $urandom_range(0, 7);
            sz  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            case ($urandom_range(0, 7))
                0, 1:    bu = 2'd0;
                7:       bu = 2'($urandom_range(2, 3));
                default: bu = 2'd1;
            endcase
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i <= len; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
                bb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
                wr(4'($urandom), $urandom, 8'(len), sz, bu, bb);
            end else begin
                rd(4'($urandom), $urandom, 8'(len), sz, bu);
            end
            wait_idle;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_spm_slave.md
AXI_SPM_SLAVE -- requirements
Module: axi_spm_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, scratchpad depth in 32-bit words (power of two, 16..4096).
REQ-002 SHALL have port clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have read-address ports arid_i 4, araddr_i 32, arlen_i 8, arsize_i 3, arburst_i 2, arvalid_i 1 (all in); arready_o 1 (out).
REQ-005 SHALL have read-data ports rid_o 4, rdata_o 32, rresp_o 2, rlast_o 1, rvalid_o 1 (all out); rready_i 1 (in).
REQ-006 SHALL have write-address ports awid_i 4, awaddr_i 32, awlen_i 8, awsize_i 3, awburst_i 2, awvalid_i 1 (all in); awready_o 1 (out).
REQ-007 SHALL have write-data ports wid_i 4, wdata_i 32, wstrb_i 4, wlast_i 1, wvalid_i 1 (all in); wready_o 1 (out).
REQ-008 SHALL have write-response ports bid_o 4, bresp_o 2, bvalid_o 1 (all out); bready_i 1 (in).

Function
REQ-009 SHALL act as an AXI4 responder backed by a DEPTH_WORDS x 32 register array; word index = byte address[log2(DEPTH_WORDS)+1:2], upper bits ignored.
REQ-010 SHALL run independent read FSM (R_IDLE, R_DATA) and write FSM (W_IDLE, W_DATA, W_RESP).
REQ-011 SHALL drive arready_o = 1 only in R_IDLE; on arvalid_i&arready_o capture id/addr/len/size/burst and enter R_DATA.
REQ-012 SHALL present the first read beat (rvalid_o=1) in the cycle after AR handshake; rdata_o, rid_o, rresp_o, rlast_o registered and held stable while rvalid_o&!rready_i.
REQ-013 SHALL advance one beat per cycle while rready_i=1, assert rlast_o on beat arlen, return to R_IDLE after last-beat handshake (next arready_o=1 one cycle later).
REQ-014 SHALL return the full 32-bit word at the current word index regardless of size; master selects lanes.
REQ-015 SHALL advance address per beat: INCR by 2^size bytes; FIXED unchanged; word index wraps modulo DEPTH_WORDS.
REQ-016 SHALL treat arsize>2 or arburst=WRAP(2'b10)/reserved(2'b11) as error: all beats rresp_o=SLVERR(2'b10), rdata_o=0, burst length still honoured; otherwise rresp_o=OKAY.
REQ-017 SHALL drive awready_o = 1 only in W_IDLE; on handshake capture fields and enter W_DATA.
REQ-018 SHALL drive wready_o = 1 only in W_DATA; each wvalid_i&wready_o beat writes byte lane k iff wstrb_i[k], address advancing per REQ-015.
REQ-019 SHALL end the data phase on beat awlen (counter, not wlast_i); any beat where wlast_i != (beat==awlen) sets an error flag.
REQ-020 SHALL suppress memory writes for the whole burst when awsize>2 or awburst not FIXED/INCR.
REQ-021 SHALL enter W_RESP the cycle after the final beat, bvalid_o=1, bid_o=captured awid, bresp_o=SLVERR if error flag or REQ-020 condition else OKAY; hold until bready_i, then W_IDLE.
REQ-022 SHALL allow read and write bursts concurrently; same-word same-cycle read returns pre-write data.
REQ-023 SHALL ignore wid_i (AXI4).

Reset
REQ-024 SHALL on rst_n_i=0 immediately force R_IDLE, W_IDLE, beat counters 0, error flag 0, rvalid_o=0, rlast_o=0, rdata_o=0, rid_o=0, rresp_o=0, bvalid_o=0, bid_o=0, bresp_o=0, wready_o=0, arready_o=1, awready_o=1.
REQ-025 SHALL abort any in-flight burst on reset without further beats or responses; memory contents are not cleared.

Verification
REQ-026 Single write: aw addr 0x10 len 0 size 2 INCR, w 0xDEADBEEF strb 0xF wlast=1 -> bvalid next cycle, bresp OKAY, bid = awid; read back addr 0x10 -> rdata 0xDEADBEEF, rlast=1.
REQ-027 Strobe: write 0x11223344 strb 0x5 over 0xFFFFFFFF at addr 0x20 -> read back 0xFF22FF44.
REQ-028 INCR burst len 3 at addr 0x3F8 (DEPTH 256) writes 1,2,3,4 -> words 254,255,0,1 hold 1,2,3,4; read burst with rready toggling 1,0,1,0 -> data stable during stalls, rlast only on 4th beat.
REQ-029 Error: arsize=3 len 1 -> two beats rresp SLVERR rdata 0; awburst WRAP len 0 -> bresp SLVERR, target word unchanged; wlast asserted on beat 0 of len 1 -> bresp SLVERR.
REQ-030 Concurrency/reset: read and write bursts overlapped complete with correct ids; rst_n_i low mid-read-burst -> rvalid_o 0 immediately, arready_o 1, earlier-written data retained.
